// File: rtl/seq_bitadd.sv
// seq_bitadd: 64-bit signed adder that computes the sum SLICE bits per clock.
// Each operation captures a and b, walks N = 64/SLICE slices from the least
// significant upward while rippling a carry register, and then raises done for
// exactly one cycle. y, carry_out and overflow keep their values from DONE
// until the next accepted start.
module seq_bitadd #(
    parameter  int SLICE = 8,
    localparam int N     = 64 / SLICE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] y,
    output logic        carry_out,
    output logic        overflow
);

    // The slice index needs at least one bit, even when N == 1.
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [63:0]     a_q, a_nx;
    logic [63:0]     b_q, b_nx;
    logic [63:0]     y_nx;
    logic            carry_q, carry_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic            carry_out_nx;
    logic            overflow_nx;

    logic [5:0]       off;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   slice_sum;
    logic             last;

    // Add the current slice of the captured operands plus the rippled carry.
    always_comb begin
        off       = 6'(int'(idx) * SLICE);
        a_sl      = a_q[off +: SLICE];
        b_sl      = b_q[off +: SLICE];
        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_q);
        last      = (idx == IW'(N - 1));
    end

    // Next-state and next-datapath values; everything holds unless a state says otherwise.
    always_comb begin
        // NOTE: every variable gets its hold value before the case, so no path can leave one unassigned and infer a latch.
        state_nx     = state;
        a_nx         = a_q;
        b_nx         = b_q;
        y_nx         = y;
        carry_nx     = carry_q;
        idx_nx       = idx;
        carry_out_nx = carry_out;
        overflow_nx  = overflow;

        case (state)
            IDLE: begin
                if (start) begin
                    a_nx     = a;
                    b_nx     = b;
                    carry_nx = 1'b0;
                    idx_nx   = '0;
                    state_nx = RUN;
                end
            end

            RUN: begin
                // Only this slice of y changes; upper slices still show the previous result.
                y_nx[off +: SLICE] = slice_sum[SLICE-1:0];
                carry_nx           = slice_sum[SLICE];
                idx_nx             = idx + IW'(1);
                if (last) begin
                    carry_out_nx = slice_sum[SLICE];
                    // Signed overflow: operands agree in sign but the sum does not.
                    overflow_nx  = (a_q[63] == b_q[63]) && (y_nx[63] != a_q[63]);
                    state_nx     = DONE;
                end
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous, active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            // NOTE: the operand registers are plain flops, not a memory array, so clearing them in reset is safe.
            a_q       <= '0;
            b_q       <= '0;
            y         <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nx;
            a_q       <= a_nx;
            b_q       <= b_nx;
            y         <= y_nx;
            carry_q   <= carry_nx;
            idx       <= idx_nx;
            carry_out <= carry_out_nx;
            overflow  <= overflow_nx;
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (state == RUN) || (state == DONE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_seq_bitadd.sv
// Testbench for seq_bitadd: three instances (SLICE = 1, 8, 64) driven by
// directed operations with hand-computed sums, done latency, reset abort
// and back-to-back start.
module tb_seq_bitadd;

    localparam int SL [3] = '{1, 8, 64};

    logic        clk = 1'b0;
    logic        rst_v   [3];
    logic        start_v [3];
    logic [63:0] a_v;
    logic [63:0] b_v;
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [63:0] y_v     [3];
    logic        co_v    [3];
    logic        ov_v    [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_bitadd #(.SLICE(1)) u_s1 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_v), .b(b_v),
        .busy(busy_v[0]), .done(done_v[0]), .y(y_v[0]),
        .carry_out(co_v[0]), .overflow(ov_v[0])
    );

    seq_bitadd #(.SLICE(8)) u_s8 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_v), .b(b_v),
        .busy(busy_v[1]), .done(done_v[1]), .y(y_v[1]),
        .carry_out(co_v[1]), .overflow(ov_v[1])
    );

    seq_bitadd #(.SLICE(64)) u_s64 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a(a_v), .b(b_v),
        .busy(busy_v[2]), .done(done_v[2]), .y(y_v[2]),
        .carry_out(co_v[2]), .overflow(ov_v[2])
    );

    task automatic check(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s slice=%0d observed=%h expected=%h", tag, SL[d], obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation on instance d; optional start pulse and operand change while busy.
    task automatic do_op(input int d, input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] ey, input logic eco, input logic eov, input bit noise);
        int n;
        int done_edge;
        int dcount;
        n         = 64 / SL[d];
        done_edge = 0;
        dcount    = 0;
        a_v        = av;
        b_v        = bv;
        start_v[d] = 1'b1;
        for (int e = 1; e <= n + 6; e++) begin
            tick();
            if (e == 1) begin
                start_v[d] = noise;
                if (noise) begin
                    a_v = ~av;
                    b_v = av ^ 64'h5A5A_5A5A_5A5A_5A5A;
                end
            end
            if (e == 2) start_v[d] = 1'b0;
            if (done_v[d]) begin
                dcount++;
                if (done_edge == 0) begin
                    done_edge = e;
                    check("y", d, y_v[d], ey);
                    check("carry_out", d, 64'(co_v[d]), 64'(eco));
                    check("overflow", d, 64'(ov_v[d]), 64'(eov));
                    check("busy_in_done", d, 64'(busy_v[d]), 64'd1);
                end
            end
            if (e == n + 3) begin
                check("idle_busy", d, 64'(busy_v[d]), 64'd0);
                check("idle_y_hold", d, y_v[d], ey);
            end
        end
        check("done_latency", d, 64'(done_edge), 64'(n + 1));
        check("done_count", d, 64'(dcount), 64'd1);
    endtask

    // Abort an operation with reset mid-RUN, then start again on the first free edge.
    task automatic rst_test(input int d);
        int n;
        int r;
        n = 64 / SL[d];
        r = (n >= 4) ? 4 : 1;
        a_v        = 64'h0123_4567_89AB_CDEF;
        b_v        = 64'h1111_2222_3333_4444;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        repeat (r - 1) tick();
        check("busy_before_rst", d, 64'(busy_v[d]), 64'd1);
        rst_v[d] = 1'b1;
        tick();
        check("rst_busy", d, 64'(busy_v[d]), 64'd0);
        check("rst_done", d, 64'(done_v[d]), 64'd0);
        check("rst_y", d, y_v[d], 64'd0);
        check("rst_co", d, 64'(co_v[d]), 64'd0);
        check("rst_ov", d, 64'(ov_v[d]), 64'd0);
        rst_v[d] = 1'b0;
        do_op(d, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'd2, 1'b1, 1'b0, 1'b0);
    endtask

    // Start held high: second operation accepted in the IDLE cycle after DONE.
    task automatic b2b_test(input int d);
        int n;
        int de1;
        int de2;
        int dcount;
        n      = 64 / SL[d];
        de1    = 0;
        de2    = 0;
        dcount = 0;
        a_v        = 64'd5;
        b_v        = 64'd6;
        start_v[d] = 1'b1;
        for (int e = 1; e <= 2 * n + 8; e++) begin
            tick();
            if (e == 1) begin
                a_v = 64'd100;
                b_v = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            if (done_v[d]) begin
                dcount++;
                if (de1 == 0) begin
                    de1 = e;
                    check("b2b_y1", d, y_v[d], 64'd11);
                end else if (de2 == 0) begin
                    de2 = e;
                    check("b2b_y2", d, y_v[d], 64'd99);
                    start_v[d] = 1'b0;
                end
            end
        end
        start_v[d] = 1'b0;
        check("b2b_lat1", d, 64'(de1), 64'(n + 1));
        check("b2b_lat2", d, 64'(de2), 64'(2 * n + 3));
        check("b2b_count", d, 64'(dcount), 64'd2);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_v[d]   = 1'b1;
            start_v[d] = 1'b1;
        end
        a_v = 64'hDEAD_BEEF_DEAD_BEEF;
        b_v = 64'h1234_5678_9ABC_DEF0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check("reset_busy", d, 64'(busy_v[d]), 64'd0);
            check("reset_done", d, 64'(done_v[d]), 64'd0);
            check("reset_y", d, y_v[d], 64'd0);
            check("reset_co", d, 64'(co_v[d]), 64'd0);
            check("reset_ov", d, 64'(ov_v[d]), 64'd0);
            start_v[d] = 1'b0;
            rst_v[d]   = 1'b0;
        end
        tick();

        for (int d = 0; d < 3; d++) begin
            do_op(d, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
            do_op(d, 64'd1029, 64'd1027, 64'd2056, 1'b0, 1'b0, 1'b1);
            do_op(d, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0);
            do_op(d, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
            do_op(d, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1, 1'b0);
            do_op(d, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b1);
            rst_test(d);
            b2b_test(d);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
